// File: rtl/dspl_arbiter.sv
// Round-robin owner selection for the shared 8-digit display, with a minimum hold
// time per owner and per-digit blinking applied on top of the owner's frame.
//
// state | meaning
// IDLE  | no owner, display blank, arbitrate among requesters
// HOLD  | owner locked in, other requests ignored until hold time elapses
// SHARE | owner keeps display until it drops or another requester asks
module dspl_arbiter #(
  parameter int HOLD_TICKS = 100000000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [47:0] frame0,
  input  logic [47:0] frame1,
  input  logic [47:0] frame2,
  input  logic [7:0]  blink_mask,
  output logic [2:0]  gnt,
  output logic        busy,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  // Leaving HOLD as the counter steps onto HOLD_TICKS-1 lets the handover edge land
  // exactly HOLD_TICKS cycles after the grant edge.
  localparam logic [HW-1:0] HOLD_END  = HW'((HOLD_TICKS >= 2) ? HOLD_TICKS - 2 : 0);
  localparam logic [BW-1:0] BLINK_END = BW'((BLINK_HALF >= 1) ? BLINK_HALF - 1 : 0);

  typedef enum logic [1:0] {IDLE, HOLD, SHARE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      last, last_nxt;
  logic [HW-1:0]   hold_cnt, hold_cnt_nxt;
  logic [BW-1:0]   blink_cnt;
  logic            phase;
  logic [2:0]      gnt_nxt;
  logic [2:0]      pick_any, pick_other;
  logic            owner_req;
  logic [47:0]     frame_sel, frame_vis, disp;

  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] from,
                                         input logic incl_self);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = '0;
    idx  = from;
    for (int k = 1; k <= 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (pick == '0 && r[idx] && (k < 3 || incl_self)) pick[idx] = 1'b1;
    end
    return pick;
  endfunction

  function automatic logic [1:0] idx_of(input logic [2:0] oh);
    return oh[1] ? 2'd1 : (oh[2] ? 2'd2 : 2'd0);
  endfunction

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    hold_cnt_nxt = hold_cnt;
    gnt_nxt      = gnt;
    pick_any     = rr_pick(req, last, 1'b1);
    pick_other   = rr_pick(req, last, 1'b0);
    owner_req    = |(req & gnt);
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (|pick_any) begin
          state_nxt    = HOLD;
          gnt_nxt      = pick_any;
          last_nxt     = idx_of(pick_any);
          hold_cnt_nxt = '0;
        end
      end
      HOLD: begin
        hold_cnt_nxt = hold_cnt + HW'(1);
        if (!owner_req) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else if (hold_cnt >= HOLD_END) begin
          state_nxt = SHARE;
        end
      end
      SHARE: begin
        if (!owner_req) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else if (|pick_other) begin
          state_nxt    = HOLD;
          gnt_nxt      = pick_other;
          last_nxt     = idx_of(pick_other);
          hold_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Digits follow the next owner so they switch on the same edge as gnt.
  always_comb begin
    frame_sel = '0;
    if (gnt_nxt[0])      frame_sel = frame0;
    else if (gnt_nxt[1]) frame_sel = frame1;
    else if (gnt_nxt[2]) frame_sel = frame2;
    frame_vis = frame_sel;
    for (int i = 0; i < 8; i++) begin
      if (!phase && blink_mask[i]) frame_vis[6*i+5] = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      last      <= 2'd2;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      disp      <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      busy     <= |gnt_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_cnt_nxt;
      disp     <= frame_vis;
      if (blink_cnt == BLINK_END) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  assign d1 = disp[5:0];
  assign d2 = disp[11:6];
  assign d3 = disp[17:12];
  assign d4 = disp[23:18];
  assign d5 = disp[29:24];
  assign d6 = disp[35:30];
  assign d7 = disp[41:36];
  assign d8 = disp[47:42];

endmodule

// File: tb/tb_dspl_arbiter.sv
// Bench for dspl_arbiter: directed scenarios with literal expectations, then random
// traffic, all compared each cycle against an ownership-level reference model.
module tb_dspl_arbiter;
  localparam int HT = 8;
  localparam int BH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [47:0] frame0, frame1, frame2;
  logic [7:0]  blink_mask;
  logic [2:0]  gnt;
  logic        busy;
  logic [5:0]  d1, d2, d3, d4, d5, d6, d7, d8;

  int checks = 0;
  int errors = 0;

  dspl_arbiter #(.HOLD_TICKS(HT), .BLINK_HALF(BH)) dut (
    .clock(clock), .reset(reset), .req(req),
    .frame0(frame0), .frame1(frame1), .frame2(frame2), .blink_mask(blink_mask),
    .gnt(gnt), .busy(busy),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    bit          has;
    logic [1:0]  owner;
    logic [1:0]  last;
    int unsigned held;
    int unsigned bcnt;
    bit          phase;
    logic [47:0] d;
    logic [2:0]  gnt;
  } model_t;

  model_t m;
  bit     model_valid = 1'b0;

  // held = number of cycles the current owner has had the display after this edge.
  function automatic model_t step(model_t c, logic rst, logic [2:0] r,
                                  logic [47:0] f0, logic [47:0] f1, logic [47:0] f2,
                                  logic [7:0] mk);
    model_t n;
    logic [47:0] f;
    int idx;
    bit found;
    n = c;
    if (rst) begin
      n.has = 0; n.owner = 0; n.last = 2; n.held = 0;
      n.bcnt = 0; n.phase = 1; n.d = '0; n.gnt = '0;
      return n;
    end
    found = 0;
    if (!c.has) begin
      for (int k = 1; k <= 3; k++) begin
        idx = (int'(c.last) + k) % 3;
        if (!found && r[idx]) begin
          found = 1; n.has = 1; n.owner = 2'(idx); n.last = 2'(idx); n.held = 1;
        end
      end
    end else if (!r[c.owner]) begin
      n.has = 0;
    end else if (c.held >= HT) begin
      for (int k = 1; k <= 2; k++) begin
        idx = (int'(c.last) + k) % 3;
        if (!found && r[idx]) begin
          found = 1; n.owner = 2'(idx); n.last = 2'(idx); n.held = 1;
        end
      end
    end else begin
      n.held = c.held + 1;
    end
    f = '0;
    if (n.has) f = (n.owner == 0) ? f0 : ((n.owner == 1) ? f1 : f2);
    for (int i = 0; i < 8; i++) begin
      if (!c.phase && mk[i]) f[6*i+5] = 1'b0;
    end
    n.d   = f;
    n.gnt = n.has ? 3'(1 << n.owner) : 3'b000;
    if (c.bcnt == BH - 1) begin
      n.bcnt  = 0;
      n.phase = !c.phase;
    end else begin
      n.bcnt = c.bcnt + 1;
    end
    return n;
  endfunction

  always @(posedge clock) begin
    m <= step(m, reset, req, frame0, frame1, frame2, blink_mask);
    if (reset) model_valid <= 1'b1;
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (model_valid) begin
      check("model_gnt", 48'(gnt), 48'(m.gnt));
      check("model_busy", 48'(busy), 48'(|m.gnt));
      check("model_digits", {d8, d7, d6, d5, d4, d3, d2, d1}, m.d);
    end
  end

  int   held;
  int   last_t, ntrans;
  logic prev_b;

  initial begin
    reset = 1'b1; req = '0; frame0 = '0; frame1 = '0; frame2 = '0; blink_mask = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // idle after reset
    repeat (20) begin
      @(negedge clock);
      check("idle_gnt", 48'(gnt), 48'(0));
      check("idle_digits", {d8, d7, d6, d5, d4, d3, d2, d1}, 48'(0));
    end

    // single request
    frame1 = 48'h21;
    req = 3'b010;
    @(negedge clock);
    check("single_gnt", 48'(gnt), 48'(3'b010));
    check("single_busy", 48'(busy), 48'(1));
    check("single_d1", 48'(d1), 48'(6'h21));
    frame1[5:0] = 6'h23;
    @(negedge clock);
    check("frame_update_d1", 48'(d1), 48'(6'h23));
    req = 3'b000;
    @(negedge clock);
    check("release_gnt", 48'(gnt), 48'(0));

    // minimum hold then handover
    req = 3'b001;
    @(negedge clock);
    check("rr_first_gnt", 48'(gnt), 48'(3'b001));
    held = 1;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) req = 3'b101;
      @(negedge clock);
      if (gnt == 3'b001) held++; else break;
    end
    check("hold_len_0", 48'(held), 48'(HT));
    check("handover_to_2", 48'(gnt), 48'(3'b100));
    req = 3'b111;
    held = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (gnt == 3'b100) held++; else break;
    end
    check("hold_len_2", 48'(held), 48'(HT));
    check("handover_to_0", 48'(gnt), 48'(3'b001));
    held = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (gnt == 3'b001) held++; else break;
    end
    check("handover_to_1", 48'(gnt), 48'(3'b010));

    // owner drop with another request pending
    req = 3'b100;
    @(negedge clock);
    check("drop_gap", 48'(gnt), 48'(0));
    @(negedge clock);
    check("regrant_2", 48'(gnt), 48'(3'b100));
    @(negedge clock);
    req = 3'b001;
    @(negedge clock);
    check("hold_drop_gap", 48'(gnt), 48'(0));
    @(negedge clock);
    check("hold_drop_regrant", 48'(gnt), 48'(3'b001));
    repeat (12) @(negedge clock);
    req = 3'b010;
    @(negedge clock);
    check("share_drop_gap", 48'(gnt), 48'(0));
    @(negedge clock);
    check("share_drop_regrant", 48'(gnt), 48'(3'b010));

    // blink on d1 and d8
    frame1 = {8{6'h3F}};
    blink_mask = 8'h81;
    @(negedge clock);
    prev_b = d1[5];
    last_t = -1;
    ntrans = 0;
    for (int t = 0; t < 24; t++) begin
      @(negedge clock);
      check("blink_steady", 48'({d7[5], d6[5], d5[5], d4[5], d3[5], d2[5]}), 48'(6'b111111));
      check("blink_pair", 48'(d8[5]), 48'(d1[5]));
      if (d1[5] !== prev_b) begin
        if (last_t >= 0) check("blink_period", 48'(t - last_t), 48'(BH));
        last_t = t;
        ntrans++;
      end
      prev_b = d1[5];
    end
    check("blink_toggles", 48'(ntrans >= 5), 48'(1));
    blink_mask = 8'h00;
    @(negedge clock);
    repeat (12) begin
      @(negedge clock);
      check("noblink_d1", 48'({d8[5], d1[5]}), 48'(2'b11));
    end

    // reset in SHARE
    check("pre_reset_gnt", 48'(gnt), 48'(3'b010));
    reset = 1'b1;
    @(negedge clock);
    check("reset_gnt", 48'(gnt), 48'(0));
    check("reset_busy", 48'(busy), 48'(0));
    check("reset_digits", {d8, d7, d6, d5, d4, d3, d2, d1}, 48'(0));
    reset = 1'b0;
    req = 3'b011;
    @(negedge clock);
    check("post_reset_gnt", 48'(gnt), 48'(3'b001));

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 2)] = ~req[$urandom_range(0, 2)];
      if ($urandom_range(0, 3) == 0) frame0 = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) frame1 = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) frame2 = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 30) == 0) blink_mask = 8'($urandom());
      reset = ($urandom_range(0, 600) == 0);
      @(negedge clock);
    end
    reset = 1'b0;
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
